pot_adc_responder: RTL and testbench

Synthesizable responder for the two-channel serial ADC link read by the paddle potentiometer readers on the JA/JB ports. It takes the master-driven chip-select and serial clock, latches two 12-bit sample words at frame start, and shifts them out MSB-first on two data lines, exactly as the PMOD ADC does. It sits behind a JA/JB loopback, or in the top-level bench, so that paddle-position logic can be exercised with known values and no physical potentiometers.

---
 rtl/pong_pkg.sv | 15 +
 rtl/sync_edge.sv | 36 +++
 rtl/pot_adc_responder.sv | 134 +++++++++++++
 tb/tb_pot_adc_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Constants shared by the pong paddle blocks and the ADC responder.
package pong_pkg;

  // Default sample format of the PMOD ADC: 4 leading zeros, then a 12-bit sample.
  localparam int unsigned DEFAULT_SAMPLE_W   = 12;
  localparam int unsigned DEFAULT_LEAD_ZEROS = 4;
  localparam int unsigned FRAME_BITS         = 16;

  // One-hot state encoding, matching the game FSM style.
  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'b001;
  localparam logic [STATE_W-1:0] ST_SHIFT = 3'b010;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'b100;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer with rise/fall pulse detection on the synchronized level.
// Flops reset to 1 so that an idle-high bus produces no spurious edge after reset.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Shift the asynchronous input through the synchronizer chain, then keep one delayed copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{1'b1}};
      dly_q  <= 1'b1;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      dly_q <= sync_q[STAGES-1];
    end
  end

  // Single-cycle edge pulses from the last stage against its delayed copy.
  always_comb begin
    rise = sync_q[STAGES-1] & ~dly_q;
    fall = ~sync_q[STAGES-1] & dly_q;
  end

endmodule

// File: rtl/pot_adc_responder.sv
// Two-channel serial ADC responder: latches two samples at frame start and shifts them
// out MSB-first on sclk falling edges, mimicking the PMOD ADC seen by the paddle readers.
module pot_adc_responder
  import pong_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = DEFAULT_SAMPLE_W,
  parameter int unsigned LEAD_ZEROS  = DEFAULT_LEAD_ZEROS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs_n,
  input  logic                sclk,
  input  logic [SAMPLE_W-1:0] sample0,
  input  logic [SAMPLE_W-1:0] sample1,
  output logic                sdata0,
  output logic                sdata1,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_abort,
  output logic [7:0]          frame_count
);

  localparam int unsigned FRAME_W = LEAD_ZEROS + SAMPLE_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  logic cs_rise;
  logic cs_fall;
  logic sclk_fall;
  logic unused_sclk_rise;

  logic [STATE_W-1:0] state_q, state_d;
  logic [FRAME_W-1:0] sh0_q, sh0_d;
  logic [FRAME_W-1:0] sh1_q, sh1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  logic [7:0]         count_q, count_d;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .din   (cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .rise  (unused_sclk_rise),
    .fall  (sclk_fall)
  );

  // Frame FSM: load on cs_n fall, shift on sclk fall, finish or abort on cs_n rise.
  // A cs_n rise takes priority over a same-cycle sclk fall.
  always_comb begin
    state_d = state_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          sh0_d   = FRAME_W'(sample0);
          sh1_d   = FRAME_W'(sample1);
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_fall) begin
          sh0_d = {sh0_q[FRAME_W-2:0], 1'b0};
          sh1_d = {sh1_q[FRAME_W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (cs_rise) begin
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, shift registers, counters and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sh0_q   <= '0;
      sh1_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      count_q <= count_d;
    end
  end

  // Data lines only carry shift-register MSBs while shifting; zero otherwise.
  always_comb begin
    sdata0      = (state_q == ST_SHIFT) & sh0_q[FRAME_W-1];
    sdata1      = (state_q == ST_SHIFT) & sh1_q[FRAME_W-1];
    busy        = (state_q == ST_SHIFT) | (state_q == ST_DONE);
    frame_done  = done_q;
    frame_abort = abort_q;
    frame_count = count_q;
  end

endmodule

// File: tb/tb_pot_adc_responder.sv
// Bench for pot_adc_responder: acts as the reader on the pins, checks every cycle
// against a frame-level model, and pins that model with hand-computed expectations.
module tb_pot_adc_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b1;
  logic        sclk = 1'b0;
  logic [11:0] sample0 = '0;
  logic [11:0] sample1 = '0;
  logic        sdata0, sdata1, busy, frame_done, frame_abort;
  logic [7:0]  frame_count;

  int checks = 0;
  int failures = 0;

  pot_adc_responder dut (
    .clk         (clk),
    .reset       (reset),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .sample0     (sample0),
    .sample1     (sample1),
    .sdata0      (sdata0),
    .sdata1      (sdata1),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Frame-level model ----------------
  // A pin edge takes effect on the outputs three clock boundaries later; history bit k
  // holds the pin as sampled k+1 edges ago.
  logic [2:0]  cs_h = 3'b111;
  logic [2:0]  sclk_h = 3'b111;
  bit          m_in_frame = 0;
  int          m_falls = 0;
  logic [15:0] m_w0 = '0;
  logic [15:0] m_w1 = '0;
  logic        m_done = 0;
  logic        m_abort = 0;
  int          m_count = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_h       <= 3'b111;
      sclk_h     <= 3'b111;
      m_in_frame <= 0;
      m_falls    <= 0;
      m_w0       <= '0;
      m_w1       <= '0;
      m_done     <= 0;
      m_abort    <= 0;
      m_count    <= 0;
    end else begin
      cs_h    <= {cs_h[1:0], cs_n};
      sclk_h  <= {sclk_h[1:0], sclk};
      m_done  <= 0;
      m_abort <= 0;
      if (m_in_frame && cs_h[1] && !cs_h[2]) begin
        m_in_frame <= 0;
        if (m_falls >= 16) begin
          m_done  <= 1;
          m_count <= (m_count + 1) % 256;
        end else begin
          m_abort <= 1;
        end
      end else if (!m_in_frame && !cs_h[1] && cs_h[2]) begin
        m_in_frame <= 1;
        m_falls    <= 0;
        m_w0       <= {4'h0, sample0};
        m_w1       <= {4'h0, sample1};
      end else if (m_in_frame && !sclk_h[1] && sclk_h[2]) begin
        m_falls <= m_falls + 1;
      end
    end
  end

  function automatic logic exp_bit(input logic [15:0] w);
    if (m_in_frame && m_falls < 16) return w[15 - m_falls];
    return 1'b0;
  endfunction

  // Per-cycle comparison, sampled away from the active edge.
  always @(negedge clk) begin
    chk("sdata0", 32'(sdata0), 32'(exp_bit(m_w0)));
    chk("sdata1", 32'(sdata1), 32'(exp_bit(m_w1)));
    chk("busy", 32'(busy), 32'(m_in_frame));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("frame_abort", 32'(frame_abort), 32'(m_abort));
    chk("frame_count", 32'(frame_count), 32'(m_count));
  end

  int n_done = 0;
  int n_abort = 0;
  always @(negedge clk) begin
    if (frame_done === 1'b1) n_done++;
    if (frame_abort === 1'b1) n_abort++;
  end

  // ---------------- Reader ----------------
  logic [31:0] cap0, cap1;
  int          cyc = 0;
  int          chg_at = -1;
  logic [11:0] chg_val = '0;

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    if (cyc == chg_at) sample0 = chg_val;
  endtask

  // sclk idles low; the reader samples sdata as it raises sclk, then drops it (shift edge).
  task automatic clock_bits(input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      cap0 = {cap0[30:0], sdata0};
      cap1 = {cap1[30:0], sdata1};
      sclk = 1'b1;
      repeat (half) tick();
      sclk = 1'b0;
      repeat (half) tick();
    end
  endtask

  task automatic run_frame(input int nfalls, input int half, input int lead);
    cap0 = '0;
    cap1 = '0;
    cyc  = 0;
    cs_n = 1'b0;
    repeat (lead) tick();
    clock_bits(nfalls, half);
    repeat (4) tick();
    cs_n = 1'b1;
    repeat (6) tick();
    chg_at = -1;
  endtask

  function automatic logic [31:0] exp_cap(input logic [11:0] s, input int n);
    logic [15:0] w;
    logic [31:0] e;
    w = {4'h0, s};
    e = '0;
    for (int k = 0; k < n; k++) begin
      if (k < 16) e = {e[30:0], w[15 - k]};
      else e = {e[30:0], 1'b0};
    end
    return e;
  endfunction

  initial begin
    int d0, a0, n;
    logic [11:0] s0, s1;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sdata0", 32'(sdata0), 32'h0);
    chk("rst_sdata1", 32'(sdata1), 32'h0);
    chk("rst_count", 32'(frame_count), 32'h0);
    chk("rst_pulses", 32'({frame_done, frame_abort}), 32'h0);
    tick();
    reset = 1'b0;
    repeat (4) tick();

    // Standard frame.
    sample0 = 12'hA5C;
    sample1 = 12'h3F0;
    d0 = n_done; a0 = n_abort;
    run_frame(16, 4, 4);
    chk("t1_cap0", cap0, 32'h0A5C);
    chk("t1_cap1", cap1, 32'h03F0);
    chk("t1_done", 32'(n_done - d0), 32'd1);
    chk("t1_abort", 32'(n_abort - a0), 32'd0);
    chk("t1_count", 32'(frame_count), 32'd1);

    // Sample change mid-frame does not disturb the frame in flight.
    chg_at = 5;
    chg_val = 12'hFFF;
    run_frame(16, 5, 5);
    chk("t2_cap0_old", cap0, 32'h0A5C);
    run_frame(16, 4, 4);
    chk("t2_cap0_new", cap0, 32'h0FFF);
    chk("t2_count", 32'(frame_count), 32'd3);

    // Abort after 9 falling edges.
    d0 = n_done; a0 = n_abort;
    run_frame(9, 4, 4);
    chk("t3_abort", 32'(n_abort - a0), 32'd1);
    chk("t3_done", 32'(n_done - d0), 32'd0);
    chk("t3_count", 32'(frame_count), 32'd3);
    chk("t3_sdata0", 32'(sdata0), 32'h0);

    // 20 edges: trailing bits are zero, one completion.
    d0 = n_done;
    run_frame(20, 4, 4);
    chk("t4_cap0", cap0, 32'h0FFF0);
    chk("t4_done", 32'(n_done - d0), 32'd1);
    chk("t4_count", 32'(frame_count), 32'd4);

    // Asynchronous reset in the middle of a frame.
    d0 = n_done; a0 = n_abort;
    cs_n = 1'b0;
    repeat (4) tick();
    clock_bits(7, 4);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_sdata0", 32'(sdata0), 32'h0);
    chk("t5_sdata1", 32'(sdata1), 32'h0);
    chk("t5_count", 32'(frame_count), 32'h0);
    cs_n = 1'b1;
    sclk = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("t5_no_pulse", 32'((n_done - d0) + (n_abort - a0)), 32'd0);
    sample0 = 12'h123;
    sample1 = 12'hEDC;
    run_frame(16, 4, 4);
    chk("t5_cap0", cap0, 32'h0123);
    chk("t5_cap1", cap1, 32'h0EDC);
    chk("t5_count_after", 32'(frame_count), 32'd1);

    // Randomized frames, including short and long ones.
    for (int f = 0; f < 24; f++) begin
      s0 = 12'($urandom);
      s1 = 12'($urandom);
      sample0 = s0;
      sample1 = s1;
      case ($urandom_range(0, 3))
        0: n = $urandom_range(1, 15);
        1: n = $urandom_range(17, 20);
        default: n = 16;
      endcase
      run_frame(n, $urandom_range(4, 6), $urandom_range(4, 7));
      chk("rnd_cap0", cap0, exp_cap(s0, n));
      chk("rnd_cap1", cap1, exp_cap(s1, n));
    end

    // 256 back-to-back frames wrap the count.
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    d0 = n_done;
    for (int f = 0; f < 256; f++) begin
      sample0 = 12'($urandom);
      sample1 = 12'($urandom);
      run_frame(16, 4, 4);
      if (f == 0 || f == 255) chk("t6_busy_gap", 32'(busy), 32'h0);
    end
    chk("t6_count_wrap", 32'(frame_count), 32'd0);
    chk("t6_done_total", 32'(n_done - d0), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
